// File: rtl/sine_ram_player.sv
// Sine playback engine: a 256-entry signed table is read by a phase accumulator,
// scaled by a Q1.15 gain and streamed out on a valid/ready master port.
// Pipeline: S1 table read, S2 data register, S3 multiply/saturate into output.
module sine_ram_player #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PHASE_W = 32
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               tbl_wr_en,
    input  logic [ADDR_W-1:0]  tbl_wr_addr,
    input  logic [DATA_W-1:0]  tbl_wr_data,
    input  logic               cfg_enable,
    input  logic [PHASE_W-1:0] cfg_phase_inc,
    input  logic [PHASE_W-1:0] cfg_phase_offset,
    input  logic [15:0]        cfg_amplitude,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [DATA_W-1:0]  m_tdata,
    output logic               busy,
    output logic [31:0]        sample_count
);

    // Product of signed sample and zero-extended 16-bit gain
    localparam int unsigned PW = DATA_W + 17;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t              state;
    logic [PHASE_W-1:0]  phase;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [DATA_W-1:0]   ram_q;
    logic [ADDR_W-1:0]   rd_addr;
    logic                s1_valid;
    logic                s2_valid;
    logic [DATA_W-1:0]   s2_data;
    logic                adv;
    logic                issue;
    logic                accept;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic [DATA_W-1:0]   sat_data;

    localparam logic signed [PW-1:0] SAT_MAX =
        {{(PW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN =
        {{(PW - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    assign adv     = !m_tvalid | m_tready;
    assign issue   = (state == StRun) & adv;
    assign accept  = m_tvalid & m_tready;
    assign rd_addr = phase[PHASE_W-1 -: ADDR_W];

    // Table RAM: write port plus registered read; NBA ordering gives read-first
    always_ff @(posedge ACLK) begin
        if (tbl_wr_en) begin
            mem[tbl_wr_addr] <= tbl_wr_data;
        end
        if (issue) begin
            ram_q <= mem[rd_addr];
        end
    end

    // Gain multiply, arithmetic shift back to Q0 and saturate to the sample range
    always_comb begin
        prod   = PW'($signed(s2_data)) * PW'($signed({1'b0, cfg_amplitude}));
        scaled = prod >>> 15;
        if (scaled > SAT_MAX) begin
            sat_data = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (scaled < SAT_MIN) begin
            sat_data = {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            sat_data = scaled[DATA_W-1:0];
        end
    end

    // Pipeline valid/data registers; everything freezes while the output stalls
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end else if (adv) begin
            s1_valid <= issue;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= ram_q;
            end
            m_tvalid <= s2_valid;
            if (s2_valid) begin
                m_tdata <= sat_data;
            end
        end
    end

    // Control FSM: phase accumulator, accepted-beat counter and registered busy
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= StIdle;
            phase        <= '0;
            sample_count <= '0;
            busy         <= 1'b0;
        end else begin
            if (accept) begin
                sample_count <= sample_count + 32'd1;
            end
            case (state)
                StIdle: begin
                    if (cfg_enable) begin
                        phase        <= cfg_phase_offset;
                        sample_count <= '0;
                        state        <= StRun;
                        busy         <= 1'b1;
                    end
                end
                StRun: begin
                    if (adv) begin
                        phase <= phase + cfg_phase_inc;
                    end
                    if (!cfg_enable) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    // Leave once the last in-flight beat is gone after this edge
                    if (!s1_valid && !s2_valid && adv) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sine_ram_player.sv
// Bench for sine_ram_player: reference samples are computed directly from the
// table contents, phase arithmetic and gain/saturation rules.
module tb_sine_ram_player;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        tbl_wr_en = 1'b0;
    logic [7:0]  tbl_wr_addr = '0;
    logic [15:0] tbl_wr_data = '0;
    logic        cfg_enable = 1'b0;
    logic [31:0] cfg_phase_inc = '0;
    logic [31:0] cfg_phase_offset = '0;
    logic [15:0] cfg_amplitude = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [15:0] m_tdata;
    logic        busy;
    logic [31:0] sample_count;

    int total = 0;
    int bad = 0;

    logic signed [15:0] tbl [256];

    sine_ram_player #(
        .ADDR_W  (8),
        .DATA_W  (16),
        .PHASE_W (32)
    ) dut (
        .ACLK             (ACLK),
        .ARESETN          (ARESETN),
        .tbl_wr_en        (tbl_wr_en),
        .tbl_wr_addr      (tbl_wr_addr),
        .tbl_wr_data      (tbl_wr_data),
        .cfg_enable       (cfg_enable),
        .cfg_phase_inc    (cfg_phase_inc),
        .cfg_phase_offset (cfg_phase_offset),
        .cfg_amplitude    (cfg_amplitude),
        .m_tvalid         (m_tvalid),
        .m_tready         (m_tready),
        .m_tdata          (m_tdata),
        .busy             (busy),
        .sample_count     (sample_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // k-th sample of a run: table at phase index, times gain, >>>15, clamp
    function automatic logic [15:0] model(input int unsigned k, input logic [31:0] off,
                                          input logic [31:0] inc, input logic [15:0] amp);
        logic [31:0] ph;
        longint      p;
        ph = off + k * inc;
        p  = longint'(tbl[ph[31:24]]) * longint'({16'd0, amp});
        p  = p >>> 15;
        if (p > 32767) return 16'h7fff;
        if (p < -32768) return 16'h8000;
        return p[15:0];
    endfunction

    // Called at a falling edge; returns at the next falling edge
    task automatic tbl_write(input int a, input logic [15:0] d);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = a[7:0];
        tbl_wr_data = d;
        tbl[a]      = d;
        @(negedge ACLK);
        tbl_wr_en   = 1'b0;
    endtask

    task automatic write_ramp();
        for (int i = 0; i < 256; i++) tbl_write(i, 16'(i * 16));
    endtask

    // Enable, collect n accepted beats, then disable and drain to idle
    task automatic run_case(input string tag, input logic [31:0] off, input logic [31:0] inc,
                            input logic [15:0] amp, input int n, input bit rnd,
                            input bit chk_lat);
        int   acc = 0;
        int   cyc = 0;
        int   first = -1;
        int   last_acc = -1;
        int   limit;
        bit   stall = 1'b0;
        bit   cnt_chk = 1'b0;
        logic [15:0] held = '0;
        limit            = n * 6 + 50;
        cfg_phase_offset = off;
        cfg_phase_inc    = inc;
        cfg_amplitude    = amp;
        m_tready         = 1'b1;
        cfg_enable       = 1'b1;
        while (1) begin
            @(negedge ACLK);
            cyc++;
            if (!cfg_enable && !busy) break;
            if (cyc > limit) begin
                check({tag, " timeout busy"}, 32'(busy), 32'd0);
                break;
            end
            if (cyc == 1) check({tag, " count cleared"}, sample_count, 32'd0);
            if (acc == n && !cnt_chk) begin
                check({tag, " count"}, sample_count, 32'(n));
                cnt_chk = 1'b1;
            end
            if (stall) check({tag, " stable"}, {15'd0, m_tvalid, m_tdata}, {15'd0, 1'b1, held});
            if (m_tvalid && first < 0) first = cyc;
            m_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (m_tvalid && m_tready) begin
                check({tag, " data"}, 32'(m_tdata), 32'(model(acc, off, inc, amp)));
                acc++;
                last_acc = cyc;
            end
            stall = m_tvalid & !m_tready;
            held  = m_tdata;
            if (acc >= n) cfg_enable = 1'b0;
        end
        cfg_enable = 1'b0;
        m_tready   = 1'b1;
        if (chk_lat) check({tag, " first valid cycle"}, 32'(first), 32'd4);
        if (rnd) check({tag, " drain<=3"}, 32'(acc - n <= 3), 32'd1);
        else check({tag, " total accepts"}, 32'(acc), 32'(n + 3));
        check({tag, " busy drop"}, 32'(cyc), 32'(last_acc + 1));
        check({tag, " final count"}, sample_count, 32'(acc));
    endtask

    initial begin
        int n;
        cfg_enable = 1'b0;
        repeat (2) @(negedge ACLK);
        check("reset tvalid", 32'(m_tvalid), 32'd0);
        check("reset tdata", 32'(m_tdata), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset count", sample_count, 32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        write_ramp();
        run_case("ramp", 32'h0, 32'h0100_0000, 16'h8000, 257, 1'b0, 1'b1);
        run_case("bp", 32'h0, 32'h0100_0000, 16'h8000, 1000, 1'b1, 1'b0);
        run_case("offset", 32'hff00_0000, 32'h0100_0000, 16'h8000, 2, 1'b0, 1'b1);
        run_case("dis", 32'h0, 32'h0100_0000, 16'h8000, 10, 1'b0, 1'b1);
        run_case("reen", 32'h0500_0000, 32'h0100_0000, 16'h8000, 5, 1'b0, 1'b1);

        tbl_write(0, 16'h7fff);
        run_case("sat_pos", 32'h0, 32'h0, 16'hffff, 8, 1'b0, 1'b1);
        run_case("half", 32'h0, 32'h0, 16'h4000, 8, 1'b0, 1'b1);
        tbl_write(0, 16'h8000);
        run_case("sat_neg", 32'h0, 32'h0, 16'hffff, 8, 1'b0, 1'b1);

        for (int i = 0; i < 256; i++) tbl_write(i, 16'($urandom()));
        run_case("rand", $urandom(), $urandom(), 16'($urandom()), 300, 1'b1, 1'b0);

        // Asynchronous reset while a beat is stalled at the output
        write_ramp();
        cfg_phase_offset = 32'h0;
        cfg_phase_inc    = 32'h0100_0000;
        cfg_amplitude    = 16'h8000;
        m_tready         = 1'b1;
        cfg_enable       = 1'b1;
        n = 0;
        for (int c = 0; c < 50 && n < 5; c++) begin
            @(negedge ACLK);
            if (m_tvalid && m_tready) n++;
        end
        check("rst accepts", 32'(n), 32'd5);
        m_tready = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst pre tvalid", 32'(m_tvalid), 32'd1);
        #1 ARESETN = 1'b0;
        #1;
        check("rst tvalid", 32'(m_tvalid), 32'd0);
        check("rst tdata", 32'(m_tdata), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst count", sample_count, 32'd0);
        cfg_enable = 1'b0;
        m_tready   = 1'b1;
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
